// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared definitions for the traffic phase controller: phase codes, light
// patterns, BCD digit width and small decode helpers.
package traffic_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    PH_INIT   = 3'd0,
    PH_RED    = 3'd1,
    PH_GREEN  = 3'd2,
    PH_YELLOW = 3'd3,
    PH_FLASH  = 3'd4
  } phase_e;

  localparam logic [2:0] LIGHT_OFF    = 3'b000;
  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_GREEN  = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b100;

  localparam int BCD_W = 4;

  // Two-digit conversion; callers guarantee values stay below 100.
  function automatic logic [2*BCD_W-1:0] bin2bcd(input int unsigned v);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    tens = BCD_W'((v / 10) % 10);
    ones = BCD_W'(v % 10);
    return {tens, ones};
  endfunction

  function automatic logic [2:0] phase_light(input phase_e p);
    logic [2:0] l;
    case (p)
      PH_RED:    l = LIGHT_RED;
      PH_GREEN:  l = LIGHT_GREEN;
      PH_YELLOW: l = LIGHT_YELLOW;
      default:   l = LIGHT_OFF;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the phase controller and the lab top level.
// The night input exists only when TRAFFIC_NIGHT_FLASH_EN is defined.
interface traffic_phase_ctrl_if;
  import traffic_phase_ctrl_pkg::*;

  logic             ped_req;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic             night;
`endif
  logic [2:0]       phase;
  logic [2:0]       light;
  logic [BCD_W-1:0] sec_tens;
  logic [BCD_W-1:0] sec_ones;
  logic             ped_pending;
  logic             ped_ack;
  logic             tick;

`ifdef TRAFFIC_NIGHT_FLASH_EN
  modport master (output ped_req, output night,
                  input phase, input light, input sec_tens, input sec_ones,
                  input ped_pending, input ped_ack, input tick);
  modport slave  (input ped_req, input night,
                  output phase, output light, output sec_tens, output sec_ones,
                  output ped_pending, output ped_ack, output tick);
`else
  modport master (output ped_req,
                  input phase, input light, input sec_tens, input sec_ones,
                  input ped_pending, input ped_ack, input tick);
  modport slave  (input ped_req,
                  output phase, output light, output sec_tens, output sec_ones,
                  output ped_pending, output ped_ack, output tick);
`endif

endinterface

// File: rtl/traffic_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, on the last
// count before wrapping to zero.
module traffic_tick_gen #(
  parameter int TICK_DIV = 16777216
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic-light phase controller with BCD countdown and pedestrian shortening
// of green. Optional night flashing mode via TRAFFIC_NIGHT_FLASH_EN.
module traffic_phase_ctrl
  import traffic_phase_ctrl_pkg::*;
#(
  parameter int TICK_DIV      = 16777216,
  parameter int RED_SEC       = 9,
  parameter int GREEN_SEC     = 6,
  parameter int YELLOW_SEC    = 3,
  parameter int PED_GREEN_SEC = 2,
  parameter int CNT_W         = 7
) (
  input  logic clk,
  input  logic rst,
  traffic_phase_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] RED_L    = CNT_W'(RED_SEC);
  localparam logic [CNT_W-1:0] GREEN_L  = CNT_W'(GREEN_SEC);
  localparam logic [CNT_W-1:0] YELLOW_L = CNT_W'(YELLOW_SEC);
  localparam logic [CNT_W-1:0] PED_L    = CNT_W'(PED_GREEN_SEC);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       light_q, light_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             tick;
  logic             night;
  logic             serve;

  traffic_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

`ifdef TRAFFIC_NIGHT_FLASH_EN
  assign night = bus.night;
`else
  assign night = 1'b0;
`endif

  assign serve = (phase_q == PH_GREEN) && pend_q;

  // A request arriving in the same cycle as service re-arms pending.
  always_comb begin
    phase_d = phase_q;
    rem_d   = rem_q;
    light_d = light_q;
    ack_d   = 1'b0;
    pend_d  = pend_q | bus.ped_req;
    if (tick) begin
      if (night) begin
        phase_d = PH_FLASH;
        rem_d   = '0;
        pend_d  = 1'b0;
        light_d = (phase_q == PH_FLASH) ? (light_q ^ LIGHT_YELLOW) : LIGHT_OFF;
      end else begin
        unique case (phase_q)
          PH_RED, PH_GREEN, PH_YELLOW: begin
            if (serve && (rem_q > PED_L)) begin
              rem_d = PED_L;
            end else if (rem_q != '0) begin
              rem_d = rem_q - ONE;
            end else begin
              unique case (phase_q)
                PH_RED:    begin phase_d = PH_GREEN;  rem_d = GREEN_L;  end
                PH_GREEN:  begin phase_d = PH_YELLOW; rem_d = YELLOW_L; end
                default:   begin phase_d = PH_RED;    rem_d = RED_L;    end
              endcase
            end
            if (serve) begin
              ack_d  = 1'b1;
              pend_d = bus.ped_req;
            end
          end
          default: begin
            phase_d = PH_RED;
            rem_d   = RED_L;
          end
        endcase
        light_d = phase_light(phase_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= PH_INIT;
      rem_q   <= RED_L;
      light_q <= LIGHT_OFF;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      rem_q   <= rem_d;
      light_q <= light_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.light       = light_q;
  assign bus.ped_pending = pend_q;
  assign bus.ped_ack     = ack_q;
  assign bus.tick        = tick;
  assign {bus.sec_tens, bus.sec_ones} = bin2bcd(32'(rem_q));

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: two instances (RED_SEC 9 and 45) with directed
// scenarios plus a randomized run against a spec-level model.
module tb_traffic_phase_ctrl;
  import traffic_phase_ctrl_pkg::*;

  localparam int TDIV   = 4;
  localparam int RED_A  = 9;
  localparam int RED_B  = 45;
  localparam int GREEN  = 6;
  localparam int YELLOW = 3;
  localparam int PEDG   = 2;
  localparam int NDUT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pedReq = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic night = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  traffic_phase_ctrl_if busA();
  traffic_phase_ctrl_if busB();

  assign busA.ped_req = pedReq;
  assign busB.ped_req = pedReq;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  assign busA.night = night;
  assign busB.night = night;
`endif

  traffic_phase_ctrl #(.TICK_DIV(TDIV), .RED_SEC(RED_A), .GREEN_SEC(GREEN),
    .YELLOW_SEC(YELLOW), .PED_GREEN_SEC(PEDG), .CNT_W(7)) dutA (
    .clk(clk), .rst(rst), .bus(busA));

  traffic_phase_ctrl #(.TICK_DIV(TDIV), .RED_SEC(RED_B), .GREEN_SEC(GREEN),
    .YELLOW_SEC(YELLOW), .PED_GREEN_SEC(PEDG), .CNT_W(7)) dutB (
    .clk(clk), .rst(rst), .bus(busB));

  always #5 clk = ~clk;

  logic [2:0] dPhase [NDUT];
  logic [2:0] dLight [NDUT];
  logic [3:0] dTens  [NDUT];
  logic [3:0] dOnes  [NDUT];
  logic       dPend  [NDUT];
  logic       dAck   [NDUT];
  logic       dTick  [NDUT];

  assign dPhase[0] = busA.phase;       assign dPhase[1] = busB.phase;
  assign dLight[0] = busA.light;       assign dLight[1] = busB.light;
  assign dTens[0]  = busA.sec_tens;    assign dTens[1]  = busB.sec_tens;
  assign dOnes[0]  = busA.sec_ones;    assign dOnes[1]  = busB.sec_ones;
  assign dPend[0]  = busA.ped_pending; assign dPend[1]  = busB.ped_pending;
  assign dAck[0]   = busA.ped_ack;     assign dAck[1]   = busB.ped_ack;
  assign dTick[0]  = busA.tick;        assign dTick[1]  = busB.tick;

  // Reference model: phases as numbers 0..4, durations looked up by phase.
  int mPhase [NDUT];
  int mRem   [NDUT];
  bit mPend  [NDUT];
  bit mAck   [NDUT];
  bit mFlash [NDUT];
  int mDiv;
  bit mTickNow, mNewPend, mServe, mNight;

  function automatic int durOf(int k, int ph);
    case (ph)
      1:       return (k == 0) ? RED_A : RED_B;
      2:       return GREEN;
      default: return YELLOW;
    endcase
  endfunction

  function automatic logic [2:0] expLight(int k);
    if (mPhase[k] == 4) return mFlash[k] ? 3'b100 : 3'b000;
    if (mPhase[k] == 0) return 3'b000;
    return 3'(1 << (mPhase[k] - 1));
  endfunction

  always @(posedge clk) begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
    mNight = night;
`else
    mNight = 1'b0;
`endif
    if (!rst) begin
      mDiv = 0;
      for (int k = 0; k < NDUT; k++) begin
        mPhase[k] = 0; mRem[k] = durOf(k, 1); mPend[k] = 0; mAck[k] = 0; mFlash[k] = 0;
      end
    end else begin
      mTickNow = (mDiv == TDIV - 1);
      mDiv = mTickNow ? 0 : mDiv + 1;
      for (int k = 0; k < NDUT; k++) begin
        mNewPend = mPend[k] | pedReq;
        mAck[k] = 0;
        if (mTickNow) begin
          if (mNight) begin
            mFlash[k] = (mPhase[k] == 4) ? !mFlash[k] : 1'b0;
            mPhase[k] = 4; mRem[k] = 0; mNewPend = 0;
          end else if (mPhase[k] == 0 || mPhase[k] == 4) begin
            mPhase[k] = 1; mRem[k] = durOf(k, 1);
          end else begin
            mServe = (mPhase[k] == 2) && mPend[k];
            if (mServe && mRem[k] > PEDG) mRem[k] = PEDG;
            else if (mRem[k] > 0) mRem[k] = mRem[k] - 1;
            else begin
              mPhase[k] = (mPhase[k] % 3) + 1;
              mRem[k] = durOf(k, mPhase[k]);
            end
            if (mServe) begin mAck[k] = 1; mNewPend = pedReq; end
          end
        end
        mPend[k] = mNewPend;
      end
    end
  end

  // Advance to the negedge just after the next tick edge.
  task automatic waitTick();
    int n = 0;
    while (dTick[0] !== 1'b1 && n < 2 * TDIV) begin @(negedge clk); n++; end
    checks++;
    if (dTick[0] !== 1'b1) begin errors++; $display("[TB] FAIL tick_timeout: tick=%b want 1", dTick[0]); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      checks++; if (dPhase[k] !== 3'd0) begin errors++; $display("[TB] FAIL rst_phase%0d: got %0d want 0", k, dPhase[k]); end
      checks++; if (dLight[k] !== 3'b000) begin errors++; $display("[TB] FAIL rst_light%0d: got %b want 000", k, dLight[k]); end
      checks++; if ({dPend[k], dAck[k], dTick[k]} !== 3'b000) begin errors++; $display("[TB] FAIL rst_flags%0d: got %b want 000", k, {dPend[k], dAck[k], dTick[k]}); end
    end
    checks++; if ({dTens[0], dOnes[0]} !== 8'h09) begin errors++; $display("[TB] FAIL rst_digitsA: got %h want 09", {dTens[0], dOnes[0]}); end
    checks++; if ({dTens[1], dOnes[1]} !== 8'h45) begin errors++; $display("[TB] FAIL rst_digitsB: got %h want 45", {dTens[1], dOnes[1]}); end
    rst = 1'b1;
  endtask

  task automatic test_tick_and_init();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (dTick[0] !== (k == 3)) begin errors++; $display("[TB] FAIL tick_cycle%0d: got %b want %b", k, dTick[0], (k == 3)); end
      if (k == 3) begin
        checks++; if (dPhase[0] !== 3'd0) begin errors++; $display("[TB] FAIL pre_tick_phase: got %0d want 0", dPhase[0]); end
      end
    end
    checks++; if (dPhase[0] !== 3'd1) begin errors++; $display("[TB] FAIL init_to_red: got %0d want 1", dPhase[0]); end
    checks++; if (dLight[0] !== 3'b001) begin errors++; $display("[TB] FAIL red_light: got %b want 001", dLight[0]); end
    checks++; if ({dTens[0], dOnes[0]} !== 8'h09) begin errors++; $display("[TB] FAIL red_digitsA: got %h want 09", {dTens[0], dOnes[0]}); end
    checks++; if ({dTens[1], dOnes[1]} !== 8'h45) begin errors++; $display("[TB] FAIL red_digitsB: got %h want 45", {dTens[1], dOnes[1]}); end
  endtask

  task automatic test_free_run();
    int cnt [4];
    int seq [$];
    int pre;
    for (int p = 0; p < 4; p++) cnt[p] = 0;
    seq.push_back(int'(dPhase[0]));
    for (int i = 1; i <= 36; i++) begin
      pre = int'(dPhase[0]);
      waitTick();
      if (i <= 21) begin
        if (pre < 4) cnt[pre]++;
        if (int'(dPhase[0]) != pre) seq.push_back(int'(dPhase[0]));
      end
      if (i == 21) begin
        checks++; if ({dPhase[0], dTens[0], dOnes[0]} !== {3'd1, 8'h09}) begin errors++; $display("[TB] FAIL cycle_back_red: got %0d/%h want 1/09", dPhase[0], {dTens[0], dOnes[0]}); end
      end
    end
    checks++; if (cnt[1] != RED_A + 1) begin errors++; $display("[TB] FAIL red_ticks: got %0d want %0d", cnt[1], RED_A + 1); end
    checks++; if (cnt[2] != GREEN + 1) begin errors++; $display("[TB] FAIL green_ticks: got %0d want %0d", cnt[2], GREEN + 1); end
    checks++; if (cnt[3] != YELLOW + 1) begin errors++; $display("[TB] FAIL yellow_ticks: got %0d want %0d", cnt[3], YELLOW + 1); end
    checks++; if (seq.size() != 4 || seq[0] != 1 || seq[1] != 2 || seq[2] != 3 || seq[3] != 1) begin errors++; $display("[TB] FAIL phase_seq: got %p want 1,2,3,1", seq); end
    checks++; if ({dPhase[1], dTens[1], dOnes[1]} !== {3'd1, 8'h09}) begin errors++; $display("[TB] FAIL b_after36: got %0d/%h want 1/09", dPhase[1], {dTens[1], dOnes[1]}); end
    checks++; if ({dPhase[0], dTens[0], dOnes[0]} !== {3'd2, 8'h01}) begin errors++; $display("[TB] FAIL a_after36: got %0d/%h want 2/01", dPhase[0], {dTens[0], dOnes[0]}); end
  endtask

  task automatic test_ped_late();
    pedReq = 1'b1; @(negedge clk); pedReq = 1'b0;
    checks++; if ({dPend[0], dAck[0]} !== 2'b10) begin errors++; $display("[TB] FAIL late_latch: got %b want 10", {dPend[0], dAck[0]}); end
    waitTick();
    checks++; if ({dPhase[0], dTens[0], dOnes[0], dPend[0], dAck[0]} !== {3'd2, 8'h00, 2'b01}) begin errors++; $display("[TB] FAIL late_service: got %0d/%h/%b want 2/00/01", dPhase[0], {dTens[0], dOnes[0]}, {dPend[0], dAck[0]}); end
    @(negedge clk);
    checks++; if (dAck[0] !== 1'b0) begin errors++; $display("[TB] FAIL late_ack_width: got %b want 0", dAck[0]); end
    waitTick();
    checks++; if ({dPhase[0], dLight[0], dTens[0], dOnes[0]} !== {3'd3, 3'b100, 8'h03}) begin errors++; $display("[TB] FAIL late_to_yellow: got %0d/%b/%h want 3/100/03", dPhase[0], dLight[0], {dTens[0], dOnes[0]}); end
  endtask

  task automatic test_ped_shorten();
    for (int n = 0; n < 8 && dPhase[0] !== 3'd1; n++) waitTick();
    pedReq = 1'b1; @(negedge clk); pedReq = 1'b0;
    checks++; if (dPend[0] !== 1'b1) begin errors++; $display("[TB] FAIL red_latch: got %b want 1", dPend[0]); end
    for (int n = 0; n < 12 && dPhase[0] !== 3'd2; n++) waitTick();
    checks++; if ({dPhase[0], dTens[0], dOnes[0], dPend[0]} !== {3'd2, 8'h06, 1'b1}) begin errors++; $display("[TB] FAIL green_entry: got %0d/%h/%b want 2/06/1", dPhase[0], {dTens[0], dOnes[0]}, dPend[0]); end
    waitTick();
    checks++; if ({dTens[0], dOnes[0], dPend[0], dAck[0]} !== {8'h02, 2'b01}) begin errors++; $display("[TB] FAIL shorten: got %h/%b want 02/01", {dTens[0], dOnes[0]}, {dPend[0], dAck[0]}); end
    @(negedge clk);
    checks++; if (dAck[0] !== 1'b0) begin errors++; $display("[TB] FAIL shorten_ack_width: got %b want 0", dAck[0]); end
    waitTick(); waitTick();
    checks++; if ({dPhase[0], dTens[0], dOnes[0]} !== {3'd2, 8'h00}) begin errors++; $display("[TB] FAIL shorten_end: got %0d/%h want 2/00", dPhase[0], {dTens[0], dOnes[0]}); end
    waitTick();
    checks++; if (dPhase[0] !== 3'd3) begin errors++; $display("[TB] FAIL shorten_yellow: got %0d want 3", dPhase[0]); end
  endtask

  task automatic test_back_to_back();
    pedReq = 1'b1;
    for (int n = 0; n < 16 && dPhase[0] !== 3'd2; n++) waitTick();
    waitTick();
    checks++; if ({dTens[0], dOnes[0], dPend[0], dAck[0]} !== {8'h02, 2'b11}) begin errors++; $display("[TB] FAIL req_wins: got %h/%b want 02/11", {dTens[0], dOnes[0]}, {dPend[0], dAck[0]}); end
    pedReq = 1'b0;
    @(negedge clk);
    checks++; if ({dPend[0], dAck[0]} !== 2'b10) begin errors++; $display("[TB] FAIL req_hold: got %b want 10", {dPend[0], dAck[0]}); end
    waitTick();
    checks++; if ({dTens[0], dOnes[0], dPend[0], dAck[0]} !== {8'h01, 2'b01}) begin errors++; $display("[TB] FAIL at_ped_value: got %h/%b want 01/01", {dTens[0], dOnes[0]}, {dPend[0], dAck[0]}); end
  endtask

  task automatic test_reset_mid_green();
    for (int n = 0; n < 1000 && dPhase[1] !== 3'd2; n++) @(negedge clk);
    checks++; if (dPhase[1] !== 3'd2) begin errors++; $display("[TB] FAIL b_green_timeout: got %0d want 2", dPhase[1]); end
    waitTick();
    pedReq = 1'b1; @(negedge clk); pedReq = 1'b0;
    checks++; if (dPend[1] !== 1'b1) begin errors++; $display("[TB] FAIL b_latch: got %b want 1", dPend[1]); end
    rst = 1'b0; @(negedge clk);
    checks++; if ({dPhase[1], dLight[1], dTens[1], dOnes[1], dPend[1], dAck[1]} !== {3'd0, 3'b000, 8'h45, 2'b00}) begin errors++; $display("[TB] FAIL mid_reset_b: got %0d/%b/%h/%b want 0/000/45/00", dPhase[1], dLight[1], {dTens[1], dOnes[1]}, {dPend[1], dAck[1]}); end
    checks++; if ({dPhase[0], dTens[0], dOnes[0]} !== {3'd0, 8'h09}) begin errors++; $display("[TB] FAIL mid_reset_a: got %0d/%h want 0/09", dPhase[0], {dTens[0], dOnes[0]}); end
    rst = 1'b1;
  endtask

`ifdef TRAFFIC_NIGHT_FLASH_EN
  task automatic test_night();
    for (int n = 0; n < 14 && dPhase[0] !== 3'd2; n++) waitTick();
    pedReq = 1'b1; @(negedge clk); pedReq = 1'b0;
    night = 1'b1;
    waitTick();
    checks++; if ({dPhase[0], dLight[0], dTens[0], dOnes[0], dPend[0], dAck[0]} !== {3'd4, 3'b000, 8'h00, 2'b00}) begin errors++; $display("[TB] FAIL flash_entry: got %0d/%b/%h/%b want 4/000/00/00", dPhase[0], dLight[0], {dTens[0], dOnes[0]}, {dPend[0], dAck[0]}); end
    waitTick();
    checks++; if (dLight[0] !== 3'b100) begin errors++; $display("[TB] FAIL flash_on: got %b want 100", dLight[0]); end
    waitTick();
    checks++; if (dLight[0] !== 3'b000) begin errors++; $display("[TB] FAIL flash_off: got %b want 000", dLight[0]); end
    night = 1'b0;
    waitTick();
    checks++; if ({dPhase[0], dLight[0], dTens[0], dOnes[0]} !== {3'd1, 3'b001, 8'h09}) begin errors++; $display("[TB] FAIL flash_exit: got %0d/%b/%h want 1/001/09", dPhase[0], dLight[0], {dTens[0], dOnes[0]}); end
    checks++; if ({dPhase[1], dTens[1], dOnes[1]} !== {3'd1, 8'h45}) begin errors++; $display("[TB] FAIL flash_exit_b: got %0d/%h want 1/45", dPhase[1], {dTens[1], dOnes[1]}); end
  endtask
`endif

  task automatic test_random();
    logic [16:0] obs, exp;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        obs = {dPhase[k], dLight[k], dTens[k], dOnes[k], dPend[k], dAck[k], dTick[k]};
        exp = {3'(mPhase[k]), expLight(k), 4'(mRem[k] / 10), 4'(mRem[k] % 10), mPend[k], mAck[k], (mDiv == TDIV - 1)};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("[TB] FAIL random_dut%0d cyc%0d: got ph=%0d lt=%b bcd=%h pa=%b tk=%b want ph=%0d lt=%b bcd=%h pa=%b tk=%b",
                   k, c, obs[16:14], obs[13:11], obs[10:3], obs[2:1], obs[0], exp[16:14], exp[13:11], exp[10:3], exp[2:1], exp[0]);
        end
      end
      pedReq = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 399) != 0);
`ifdef TRAFFIC_NIGHT_FLASH_EN
      if ($urandom_range(0, 59) == 0) night = ~night;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_tick_and_init();
    test_free_run();
    test_ped_late();
    test_ped_shorten();
    test_back_to_back();
    test_reset_mid_green();
`ifdef TRAFFIC_NIGHT_FLASH_EN
    test_night();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
